// File: rtl/pe_result_pkg.sv
// rtl/pe_result_pkg.sv - shared sizes, occupancy states and lane-slice helper for the PE result collector
package pe_result_pkg;

    localparam int NUM_PE = 8;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 3;
    localparam int FRM_W  = 16;
    localparam int BUS_W  = NUM_PE * DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

    // Lane 0 sits in the MSBs of the packed bus.
    function automatic logic [DATA_W-1:0] lane_slice(
        input logic [BUS_W-1:0] bus,
        input logic [IDX_W-1:0] k
    );
        lane_slice = bus[(NUM_PE - int'(k)) * DATA_W - 1 -: DATA_W];
    endfunction

endpackage

// File: rtl/pe_frame_bank.sv
// rtl/pe_frame_bank.sv - two-slot ping-pong frame store with write/read pointers and lane mux
//   clk, reset   : clock, asynchronous active-low reset
//   wr_en        : capture wr_data into the slot at the write pointer
//   wr_data      : packed frame (NUM_PE lanes)
//   rd_done      : current read slot fully streamed, advance read pointer
//   lane_idx     : lane selected from the read slot
//   rd_data      : selected lane result
module pe_frame_bank
    import pe_result_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [BUS_W-1:0]  wr_data,
    input  logic              rd_done,
    input  logic [IDX_W-1:0]  lane_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [BUS_W-1:0] slot0_q;
    logic [BUS_W-1:0] slot1_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;

    // Slots are cleared on reset so the read mux presents zero afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot0_q  <= '0;
            slot1_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_ptr_q) begin
                    slot1_q <= wr_data;
                end else begin
                    slot0_q <= wr_data;
                end
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (rd_done) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign rd_data = lane_slice(rd_ptr_q ? slot1_q : slot0_q, lane_idx);

endmodule

// File: rtl/pe_result_collector.sv
// rtl/pe_result_collector.sv - captures PE array frames into a ping-pong bank and streams them lane by lane
//   clk, reset   : clock, asynchronous active-low reset
//   in_valid_i   : capture strobe for in_data_i
//   in_ready_o   : bank has a free slot
//   in_data_i    : packed NUM_PE x DATA_W results, lane 0 in the MSBs
//   out_valid_o  : out_data_o holds a valid word
//   out_ready_i  : consumer accepts the word
//   out_data_o   : current lane result
//   out_idx_o    : lane index of out_data_o
//   out_last_o   : high on the final lane of a frame
//   out_frame_o  : sequence number of the frame being streamed
//   drop_o       : one-cycle pulse after a frame was discarded
//   drop_cnt_o   : saturating count of discarded frames
module pe_result_collector
    import pe_result_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [BUS_W-1:0]  in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [IDX_W-1:0]  out_idx_o,
    output logic              out_last_o,
    output logic [FRM_W-1:0]  out_frame_o,
    output logic              drop_o,
    output logic [7:0]        drop_cnt_o
);

    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_PE - 1);

    occ_state_t       state_q;
    occ_state_t       state_d;
    logic [IDX_W-1:0] lane_q;
    logic [FRM_W-1:0] frame_q;
    logic             drop_q;
    logic [7:0]       drop_cnt_q;

    logic push;
    logic accept;
    logic pop;
    logic overflow;

    // Ready comes straight from the state register; a pop while FULL does
    // not open the slot until the following cycle.
    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_last_o  = (lane_q == LAST_LANE);

    assign push     = in_valid_i && in_ready_o;
    assign accept   = out_valid_o && out_ready_i;
    assign pop      = accept && out_last_o;
    assign overflow = in_valid_i && (state_q == FULL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (push) state_d = ONE;
            end
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL: begin
                if (pop) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            lane_q     <= '0;
            frame_q    <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lane_q <= out_last_o ? '0 : lane_q + IDX_W'(1);
            end
            if (pop) begin
                frame_q <= frame_q + FRM_W'(1);
            end
            drop_q <= overflow;
            if (overflow && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    pe_frame_bank u_bank (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (push),
        .wr_data  (in_data_i),
        .rd_done  (pop),
        .lane_idx (lane_q),
        .rd_data  (out_data_o)
    );

    assign out_idx_o   = lane_q;
    assign out_frame_o = frame_q;
    assign drop_o      = drop_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_pe_result_collector.sv
// tb/tb_pe_result_collector.sv - directed self-checking bench with a frame-queue reference model
module tb_pe_result_collector;

    logic         clk;
    logic         reset;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [255:0] in_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [31:0]  out_data_o;
    logic [2:0]   out_idx_o;
    logic         out_last_o;
    logic [15:0]  out_frame_o;
    logic         drop_o;
    logic [7:0]   drop_cnt_o;

    pe_result_collector dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_idx_o   (out_idx_o),
        .out_last_o  (out_last_o),
        .out_frame_o (out_frame_o),
        .drop_o      (drop_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of whole frames (at most two), the lane being
    // offered from the head frame, the head frame's sequence number, and the
    // drop bookkeeping.
    logic [255:0] mq[$];
    int           m_lane;
    int           m_frame;
    int           m_drop_cnt;
    bit           m_drop;
    int           m_sz;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_lane     = 0;
            m_frame    = 0;
            m_drop_cnt = 0;
            m_drop     = 0;
        end else begin
            m_sz   = mq.size();
            m_drop = in_valid_i && (m_sz == 2);
            if (m_drop && m_drop_cnt < 255) m_drop_cnt++;
            if (m_sz > 0 && out_ready_i) begin
                if (m_lane == 7) begin
                    void'(mq.pop_front());
                    m_lane  = 0;
                    m_frame = (m_frame + 1) % 65536;
                end else begin
                    m_lane++;
                end
            end
            if (in_valid_i && m_sz < 2) mq.push_back(in_data_i);
        end
    end

    function automatic logic [31:0] lane_of(input logic [255:0] f, input int k);
        return f[(8 - k) * 32 - 1 -: 32];
    endfunction

    function automatic logic [255:0] mk_frame(input logic [31:0] base);
        logic [255:0] f;
        f = '0;
        for (int k = 0; k < 8; k++) f[(8 - k) * 32 - 1 -: 32] = base + 32'(k);
        return f;
    endfunction

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ready_low = 0;
    int drop_seen = 0;

    int          lg_cyc[$];
    logic [31:0] lg_data[$];
    int          lg_idx[$];
    int          lg_last[$];
    int          lg_frm[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, plus logging of accepted words.
    task automatic cmp_cycle();
        bit ev;
        cyc++;
        if (!reset) return;
        ev = (mq.size() > 0);
        chk("out_valid", 64'(out_valid_o), 64'(ev));
        chk("in_ready", 64'(in_ready_o), 64'(mq.size() < 2));
        chk("drop", 64'(drop_o), 64'(m_drop));
        chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drop_cnt));
        if (ev) begin
            chk("out_data", 64'(out_data_o), 64'(lane_of(mq[0], m_lane)));
            chk("out_idx", 64'(out_idx_o), 64'(m_lane));
            chk("out_last", 64'(out_last_o), 64'(m_lane == 7));
            chk("out_frame", 64'(out_frame_o), 64'(m_frame));
        end
        if (out_valid_o && out_ready_i) begin
            lg_cyc.push_back(cyc);
            lg_data.push_back(out_data_o);
            lg_idx.push_back(int'(out_idx_o));
            lg_last.push_back(int'(out_last_o));
            lg_frm.push_back(int'(out_frame_o));
        end
        if (!in_ready_o) ready_low++;
        if (drop_o) drop_seen++;
    endtask

    task automatic drive_cycle(input bit v, input logic [255:0] d, input bit r);
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        @(negedge clk);
        cmp_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hand-written expectations for one logged frame: lanes base+k, idx k,
    // last only on lane 7, fixed frame number.
    task automatic chk_frame(input int at, input logic [31:0] base, input int frm);
        chk("log_len", 64'(lg_data.size() >= at + 8), 64'd1);
        if (lg_data.size() >= at + 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("log_data", 64'(lg_data[at + k]), 64'(base + 32'(k)));
                chk("log_idx", 64'(lg_idx[at + k]), 64'(k));
                chk("log_last", 64'(lg_last[at + k]), 64'(k == 7));
                chk("log_frame", 64'(lg_frm[at + k]), 64'(frm));
            end
        end
    endtask

    task automatic chk_contig(input int at, input int n);
        if (lg_cyc.size() >= at + n) begin
            for (int k = 1; k < n; k++)
                chk("no_bubble", 64'(lg_cyc[at + k] - lg_cyc[at + k - 1]), 64'd1);
        end
    endtask

    int at;
    int rl0;
    int ds0;
    int guard;
    bit pat[4];

    initial begin
        reset       = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_data", 64'(out_data_o), 64'd0);
        chk("rst_out_idx", 64'(out_idx_o), 64'd0);
        chk("rst_out_last", 64'(out_last_o), 64'd0);
        chk("rst_out_frame", 64'(out_frame_o), 64'd0);
        chk("rst_drop", 64'(drop_o), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);

        // Single frame, ready held high
        at  = lg_data.size();
        rl0 = ready_low;
        drive_cycle(1'b1, mk_frame(32'h1000_0000), 1'b1);
        repeat (10) drive_cycle(1'b0, '0, 1'b1);
        chk_frame(at, 32'h1000_0000, 0);
        chk_contig(at, 8);
        chk("t1_words", 64'(lg_data.size() - at), 64'd8);
        chk("t1_ready_low", 64'(ready_low - rl0), 64'd0);

        // Backpressure 1,0,0,1,...
        at = lg_data.size();
        drive_cycle(1'b1, mk_frame(32'h1000_0000), 1'b0);
        guard = 0;
        while ((lg_data.size() - at) < 8 && guard < 64) begin
            drive_cycle(1'b0, '0, pat[guard % 4]);
            guard++;
        end
        chk("t2_timeout", 64'(lg_data.size() - at), 64'd8);
        chk_frame(at, 32'h1000_0000, 1);
        repeat (3) drive_cycle(1'b0, '0, 1'b1);

        // Two frames back to back
        at  = lg_data.size();
        rl0 = ready_low;
        drive_cycle(1'b1, mk_frame(32'hAAAA_0000), 1'b1);
        drive_cycle(1'b1, mk_frame(32'hBBBB_0000), 1'b1);
        repeat (20) drive_cycle(1'b0, '0, 1'b1);
        chk_frame(at, 32'hAAAA_0000, 2);
        chk_frame(at + 8, 32'hBBBB_0000, 3);
        chk_contig(at, 16);
        chk("t3_full_cycles", 64'(ready_low - rl0), 64'd7);

        // Overflow: three strobes while stalled
        at  = lg_data.size();
        ds0 = drop_seen;
        drive_cycle(1'b1, mk_frame(32'h1111_0000), 1'b0);
        drive_cycle(1'b1, mk_frame(32'h2222_0000), 1'b0);
        drive_cycle(1'b1, mk_frame(32'h3333_0000), 1'b0);
        repeat (3) drive_cycle(1'b0, '0, 1'b0);
        chk("t4_drop_pulses", 64'(drop_seen - ds0), 64'd1);
        chk("t4_drop_cnt", 64'(drop_cnt_o), 64'd1);
        repeat (20) drive_cycle(1'b0, '0, 1'b1);
        chk("t4_words", 64'(lg_data.size() - at), 64'd16);
        chk_frame(at, 32'h1111_0000, 4);
        chk_frame(at + 8, 32'h2222_0000, 5);

        // Push on the same edge that accepts lane 7
        at  = lg_data.size();
        rl0 = ready_low;
        ds0 = drop_seen;
        drive_cycle(1'b1, mk_frame(32'hC000_0000), 1'b1);
        repeat (7) drive_cycle(1'b0, '0, 1'b1);
        drive_cycle(1'b1, mk_frame(32'hD000_0000), 1'b1);
        repeat (10) drive_cycle(1'b0, '0, 1'b1);
        chk_frame(at, 32'hC000_0000, 6);
        chk_frame(at + 8, 32'hD000_0000, 7);
        chk_contig(at, 16);
        chk("t5_ready_low", 64'(ready_low - rl0), 64'd0);
        chk("t5_no_drop", 64'(drop_seen - ds0), 64'd0);
        chk("t5_drop_cnt", 64'(drop_cnt_o), 64'd1);

        // Reset mid-frame with a second frame buffered
        drive_cycle(1'b1, mk_frame(32'hE000_0000), 1'b1);
        drive_cycle(1'b1, mk_frame(32'hF000_0000), 1'b1);
        drive_cycle(1'b0, '0, 1'b1);
        drive_cycle(1'b0, '0, 1'b1);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        chk("t6_pre_idx", 64'(out_idx_o), 64'd3);
        chk("t6_pre_data", 64'(out_data_o), 64'hE000_0003);
        chk("t6_pre_ready", 64'(in_ready_o), 64'd0);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid_o), 64'd0);
        chk("t6_rst_data", 64'(out_data_o), 64'd0);
        chk("t6_rst_idx", 64'(out_idx_o), 64'd0);
        chk("t6_rst_last", 64'(out_last_o), 64'd0);
        chk("t6_rst_frame", 64'(out_frame_o), 64'd0);
        chk("t6_rst_drop", 64'(drop_o), 64'd0);
        chk("t6_rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rel_ready", 64'(in_ready_o), 64'd1);
        chk("t6_rel_valid", 64'(out_valid_o), 64'd0);
        chk("t6_rel_drop_cnt", 64'(drop_cnt_o), 64'd0);
        chk("t6_rel_frame", 64'(out_frame_o), 64'd0);

        // Fresh frame after reset restarts numbering, nothing replayed
        at = lg_data.size();
        drive_cycle(1'b1, mk_frame(32'h5A5A_0000), 1'b1);
        repeat (10) drive_cycle(1'b0, '0, 1'b1);
        chk("t7_words", 64'(lg_data.size() - at), 64'd8);
        chk_frame(at, 32'h5A5A_0000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_result_collector.md
Name: pe_result_collector

Overview:
- Downstream stage of the PE array: captures the concatenated 8×32-bit `final_result` bus in one cycle, on an upstream capture strobe.
- Buffers up to two frames in a ping-pong bank.
- Serialises each frame as one 32-bit word per cycle over a valid/ready stream, tagged with lane index, last flag and frame number.
- Feeds the host/file-writer path and counts frames lost to overflow.

Parameters:
- NUM_PE, 8, number of PE lanes per frame
- DATA_W, 32, width of one PE result
- IDX_W, 3, lane index width; equals clog2(NUM_PE)
- FRM_W, 16, frame counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid_i  in  1  capture strobe; frame present on in_data_i
- in_ready_o  out  1  bank has a free slot
- in_data_i  in  NUM_PE*DATA_W  packed results; lane k at bits [(NUM_PE-k)*DATA_W-1 -: DATA_W], so lane 0 is in the MSBs
- out_valid_o  out  1  out_data_o holds a valid word
- out_ready_i  in  1  consumer accepts the word
- out_data_o  out  DATA_W  current lane result
- out_idx_o  out  IDX_W  lane index of out_data_o
- out_last_o  out  1  high with lane NUM_PE-1
- out_frame_o  out  FRM_W  sequence number of the frame being streamed
- drop_o  out  1  one-cycle pulse: a frame was discarded
- drop_cnt_o  out  8  saturating count of discarded frames

Behaviour:
- Reset (reset=0, asynchronous):
  - bank empty; wr_ptr, rd_ptr, lane index, frame counter and drop_cnt all 0.
  - out_valid_o=0, out_data_o=0, out_idx_o=0, out_last_o=0, out_frame_o=0, drop_o=0.
  - in_ready_o=1 from the first cycle after release.
- Occupancy FSM, states EMPTY, ONE, FULL:
  - push = in_valid_i && in_ready_o
  - pop = out_valid_o && out_ready_i && out_last_o
  - EMPTY→ONE on push.
  - ONE→FULL on push without pop; ONE→EMPTY on pop without push; ONE stays ONE on simultaneous push and pop.
  - FULL→ONE on pop.
- in_ready_o = (state != FULL). It is decoded from registers only; there is no same-cycle pass-through when a pop coincides with FULL.
- Capture:
  - On push, the whole in_data_i is registered into slot wr_ptr, then wr_ptr toggles.
  - Capture is a single cycle; upstream need not hold data.
- Overflow:
  - in_valid_i while FULL discards the frame; bank contents are unchanged.
  - drop_o pulses in the following cycle.
  - drop_cnt_o increments and saturates at 255.
- Streaming:
  - out_valid_o = (state != EMPTY).
  - out_data_o = slot[rd_ptr] lane[lane_idx], muxed from registers.
  - Latency: a frame pushed at edge N drives its lane 0 word in the cycle after edge N when the bank was EMPTY.
  - Lane advances only on out_valid_o && out_ready_i. While out_ready_i=0, data, idx, last and frame stay stable.
  - At lane NUM_PE-1, out_last_o=1. Accepting that word triggers pop: lane_idx wraps to 0, rd_ptr toggles, out_frame_o increments (wraps at 2^FRM_W).
  - Back-to-back frames stream with no bubble.
- Reset mid-stream discards all buffered frames and any partially streamed frame; nothing is replayed.
- Width rules:
  - All counters wrap modulo their width, except drop_cnt_o, which saturates.
  - No arithmetic is applied to result data.

Decomposition:
- Shared package `pe_result_pkg`:
  - NUM_PE, DATA_W, IDX_W, FRM_W
  - occupancy state enum (EMPTY, ONE, FULL)
  - lane-slice helper function for the packed bus
- One natural sub-module, `pe_frame_bank`: the 2-slot register bank with write/read pointers and the lane mux.
- The FSM, counters and handshake stay in the top.

Test Plan:
- Single frame, lanes = 32'h1000_0000+k, out_ready_i=1:
  - 8 consecutive words 0x10000000..0x10000007, idx 0..7.
  - out_last_o only with idx 7; out_frame_o=0.
  - out_valid_o drops after that word; in_ready_o=1 throughout.
- Backpressure: same frame, out_ready_i toggling 1,0,0,1,…:
  - each word held stable while ready=0; order and values unchanged.
  - no word is duplicated or skipped.
- Two frames on consecutive cycles (A=0xAAAA000k, B=0xBBBB000k), ready=1:
  - 16 words with no gap; out_frame_o=0 for A, 1 for B.
  - in_ready_o=0 for exactly the cycles the bank is FULL.
- Overflow: three strobes on consecutive cycles with out_ready_i=0:
  - third frame discarded; drop_o pulses once; drop_cnt_o=1.
  - later streaming yields only frames 1 and 2.
- Simultaneous push and pop in state ONE, capture on the same edge that accepts idx 7:
  - state stays ONE; next word is the new frame's lane 0; no drop.
- Reset asserted (low) mid-frame at idx 3, with a second frame buffered:
  - all outputs 0 immediately; after release in_ready_o=1, out_valid_o=0, drop_cnt_o=0, out_frame_o=0.
